core_mem_dumper: RTL and testbench
==================================

// Module: core_mem_dumper
// PURPOSE
// Post-execution result extractor sitting downstream of the core's console port.
// - Watches the fetch stream and detects program halt (NOP / self-jump loop).
// - Counts run cycles and stall cycles while the program executes.
// - Then sweeps data BLOCKMEM through the console read port.
// - Streams every {address, word} pair out over a valid/ready handshake, for an off-chip checker or a UART.
// PARAMETERS
// HALT_COUNT  10    consecutive cycles with an unchanged if_inst that declare halt
// DEPTH       1024  words swept; addresses 0..DEPTH-1
// AW          10    address width; DEPTH <= 2**AW
// RD_LAT      1     cycles from con_addr change to valid con_out
// PORTS
// CLK          in   1   clock
// nrst         in   1   reset, synchronous, active-low
// if_inst      in   32  core fetch-stage instruction
// if_stall     in   1   core fetch-stage stall
// con_write    out  4   console byte-write enables; constant 4'h0 (read-only use)
// con_addr     out  AW  console word address
// con_in       out  32  console write data; constant 0
// con_out      in   32  console read data, valid RD_LAT cycles after con_addr
// dump_valid   out  1   dump_addr/dump_data valid
// dump_ready   in   1   sink accepts the current word
// dump_addr    out  AW  address of the streamed word
// dump_data    out  32  memory word
// dump_last    out  1   high with the DEPTH-1 word
// done         out  1   sweep complete; sticky until reset
// cycle_count  out  32  cycles spent in RUN
// stall_count  out  32  RUN cycles with if_stall=1
// BEHAVIOUR
// Reset (nrst=0 at posedge), all values 0:
// - Outputs: con_addr, dump_*, done, cycle_count, stall_count.
// - Internals: last_inst, match counter; state=RUN.
// - Reset mid-sweep aborts the sweep. No partial-word handshake survives it.
// FSM states: RUN -> ISSUE -> WAIT -> SEND -> (ISSUE | DONE).
// RUN:
// - cycle_count +1 every cycle; stall_count +1 when if_stall. Both saturate at 32'hFFFF_FFFF.
// - Each cycle: if_inst==last_inst -> match+1, else match=0 and last_inst<=if_inst.
// - When match reaches HALT_COUNT: go to ISSUE; counters freeze from that cycle.
// - last_inst resets to 0, so a stream of zeros at reset counts as matching.
// ISSUE: drive con_addr=idx, load wait counter with RD_LAT, go to WAIT.
// WAIT:
// - Decrement the wait counter.
// - At 0: capture con_out into dump_data, idx into dump_addr; set dump_valid; go to SEND.
// SEND:
// - dump_valid, dump_addr, dump_data, dump_last are held stable until dump_ready=1 at a posedge.
// - After the transfer, dump_valid drops in the next cycle; no back-to-back words.
// - If idx==DEPTH-1: go to DONE. Otherwise idx+1 and go to ISSUE.
// - dump_ready held low stalls the block indefinitely with no loss.
// - dump_ready high before valid has no effect.
// DONE: done=1; con_addr holds DEPTH-1; outputs static until reset.
// Throughput: one word per RD_LAT+2 cycles when dump_ready is tied high.
// Word 0 appears with dump_valid=1 exactly RD_LAT+2 cycles after the halt-detect edge.
// idx is AW+1 bits wide internally, so DEPTH=2**AW does not wrap before the last compare.
// STRUCTURE
// Package core_dbg_pkg holds:
// - dumper state enum (RUN, ISSUE, WAIT, SEND, DONE)
// - DEFAULT_HALT_COUNT, DEFAULT_DEPTH
// One sub-module halt_detector: inputs CLK, nrst, if_inst, enable; output halted (sticky).
// It owns last_inst and the match counter. The FSM, counters and handshake live in the top.
// TESTING
// 1. if_inst = 0x13 constant after 40 cycles of varied code, 3 stall cycles -> halt exactly 10 cycles
//    after the first repeat; cycle_count frozen at the entry cycle count; stall_count=3.
// 2. BRAM model preloaded with mem[i]=i*4+0xA5, dump_ready=1 -> 1024 transfers in order,
//    addr 0..1023, data matches, dump_last only on addr 1023, then done=1.
// 3. dump_ready random 30% duty -> no dropped or duplicated words; dump_addr/dump_data stable while valid&&!ready.
// 4. nrst=0 pulsed at word 500 of the sweep -> next cycle all outputs 0, state RUN;
//    a re-run restarts from addr 0.
// 5. Alternating if_inst A,B,A,B for 1000 cycles -> no halt, cycle_count=1000;
//    then A for 10 cycles -> halt.
// 6. RD_LAT=2 build -> the captured word equals mem[con_addr], with no one-word skew.

Source files
------------

// File: rtl/core_dbg_pkg.sv
// Shared types and defaults for the core debug/dump blocks.
package core_dbg_pkg;

  // Dumper sequencing: run the program, then read/stream every word.
  typedef enum logic [2:0] {
    RUN,
    ISSUE,
    WAIT,
    SEND,
    DONE
  } dumper_state_e;

  localparam int DEFAULT_HALT_COUNT = 10;
  localparam int DEFAULT_DEPTH      = 1024;
  localparam int DEFAULT_AW         = 10;
  localparam int DEFAULT_RD_LAT     = 1;

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/core_mem_dumper_halt_detector.sv
// Declares the program halted once the fetched instruction stays unchanged
// for HALT_COUNT consecutive sampled cycles (NOP or self-jump loop).
module halt_detector import core_dbg_pkg::*; #(
  parameter int HALT_COUNT = DEFAULT_HALT_COUNT
) (
  input  logic        CLK,
  input  logic        nrst,
  input  logic [31:0] if_inst,
  input  logic        enable,
  output logic        halted
);

  localparam int MW = $clog2(HALT_COUNT + 1);

  logic [31:0]   r_last_inst;
  logic [MW-1:0] r_match;
  logic          w_halted;

  // Match counter stops at HALT_COUNT, which makes halted sticky until reset.
  assign w_halted = (r_match == MW'(HALT_COUNT));
  assign halted   = w_halted;

  // Track the previous instruction and count consecutive repeats.
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      r_last_inst <= '0;
      r_match     <= '0;
    end else if (enable && !w_halted) begin
      if (if_inst == r_last_inst) begin
        r_match <= r_match + 1'b1;
      end else begin
        r_match     <= '0;
        r_last_inst <= if_inst;
      end
    end
  end

endmodule

// File: rtl/core_mem_dumper.sv
// Post-execution result extractor: waits for the core to halt, counts run and
// stall cycles, then sweeps data memory through the console read port and
// streams {address, word} pairs over a valid/ready handshake.
module core_mem_dumper import core_dbg_pkg::*; #(
  parameter int HALT_COUNT = DEFAULT_HALT_COUNT,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AW         = DEFAULT_AW,
  parameter int RD_LAT     = DEFAULT_RD_LAT
) (
  input  logic          CLK,
  input  logic          nrst,
  input  logic [31:0]   if_inst,
  input  logic          if_stall,
  output logic [3:0]    con_write,
  output logic [AW-1:0] con_addr,
  output logic [31:0]   con_in,
  input  logic [31:0]   con_out,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [31:0]   dump_data,
  output logic          dump_last,
  output logic          done,
  output logic [31:0]   cycle_count,
  output logic [31:0]   stall_count
);

  localparam int WW = $clog2(RD_LAT + 1);

  dumper_state_e r_state, w_state_nxt;
  logic [AW:0]     r_idx;
  logic [WW-1:0]   r_wait;
  logic [AW-1:0]   r_con_addr;
  logic            r_dump_valid;
  logic [AW-1:0]   r_dump_addr;
  logic [31:0]     r_dump_data;
  logic            r_dump_last;
  logic            r_done;
  logic [31:0]     r_cycle_count;
  logic [31:0]     r_stall_count;

  logic w_run, w_halted, w_is_last, w_wait_exp;
  logic w_cnt_en, w_issue, w_capture, w_xfer;

  assign w_run      = (r_state == RUN);
  // idx carries one spare bit so DEPTH == 2**AW never wraps before this compare.
  assign w_is_last  = (r_idx == (AW+1)'(DEPTH - 1));
  // con_addr is already stable during ISSUE, so the read returns after RD_LAT WAIT cycles.
  assign w_wait_exp = (r_wait == WW'(1));

  halt_detector #(
    .HALT_COUNT (HALT_COUNT)
  ) u_halt (
    .CLK     (CLK),
    .nrst    (nrst),
    .if_inst (if_inst),
    .enable  (w_run),
    .halted  (w_halted)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!nrst) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // Next-state: run until halt, then issue/wait/send per word until the last one.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_halted) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (w_wait_exp) w_state_nxt = SEND;
      SEND:    if (dump_ready) w_state_nxt = w_is_last ? DONE : ISSUE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = RUN;
    endcase
  end

  // Per-state control strobes for the datapath registers.
  always_comb begin
    w_cnt_en  = 1'b0;
    w_issue   = 1'b0;
    w_capture = 1'b0;
    w_xfer    = 1'b0;
    case (r_state)
      RUN:     w_cnt_en  = !w_halted;
      ISSUE:   w_issue   = 1'b1;
      WAIT:    w_capture = w_wait_exp;
      SEND:    w_xfer    = dump_ready;
      default: ;
    endcase
  end

  // Read-latency countdown, loaded on every issued address.
  always_ff @(posedge CLK) begin
    if (!nrst)                r_wait <= '0;
    else if (w_issue)         r_wait <= WW'(RD_LAT);
    else if (r_state == WAIT) r_wait <= r_wait - 1'b1;
  end

  // Sweep index, console address, captured word and handshake outputs.
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      r_idx        <= '0;
      r_con_addr   <= '0;
      r_dump_valid <= 1'b0;
      r_dump_addr  <= '0;
      r_dump_data  <= '0;
      r_dump_last  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_issue) r_con_addr <= r_idx[AW-1:0];
      if (w_capture) begin
        r_dump_valid <= 1'b1;
        r_dump_addr  <= r_idx[AW-1:0];
        r_dump_data  <= con_out;
        r_dump_last  <= w_is_last;
      end
      if (w_xfer) begin
        r_dump_valid <= 1'b0;
        r_dump_last  <= 1'b0;
        if (w_is_last) begin
          r_done <= 1'b1;
        end else begin
          r_idx      <= r_idx + 1'b1;
          r_con_addr <= AW'(r_idx + 1'b1);
        end
      end
    end
  end

  // Run/stall counters, live only while the program runs and not yet halted.
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      r_cycle_count <= '0;
      r_stall_count <= '0;
    end else if (w_cnt_en) begin
      r_cycle_count <= sat_inc32(r_cycle_count);
      if (if_stall) r_stall_count <= sat_inc32(r_stall_count);
    end
  end

  assign con_write   = 4'h0;
  assign con_in      = 32'd0;
  assign con_addr    = r_con_addr;
  assign dump_valid  = r_dump_valid;
  assign dump_addr   = r_dump_addr;
  assign dump_data   = r_dump_data;
  assign dump_last   = r_dump_last;
  assign done        = r_done;
  assign cycle_count = r_cycle_count;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_core_mem_dumper.sv
// Bench for core_mem_dumper: halt detection table, full sweeps with a
// scoreboard, random backpressure, mid-sweep reset, and a RD_LAT=2 instance.
module tb_core_mem_dumper;

  localparam int AW     = 10;
  localparam int DEPTH  = 1024;
  localparam int AW2    = 4;
  localparam int DEPTH2 = 16;
  localparam logic [31:0] INST_A = 32'hDEAD_0001;
  localparam logic [31:0] INST_B = 32'hDEAD_0002;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic           nrst;
  logic [31:0]    if_inst;
  logic           if_stall;
  logic           dump_ready;

  logic [3:0]     con_write;
  logic [AW-1:0]  con_addr;
  logic [31:0]    con_in;
  logic [31:0]    con_out;
  logic           dump_valid, dump_last, done;
  logic [AW-1:0]  dump_addr;
  logic [31:0]    dump_data, cycle_count, stall_count;

  logic [3:0]     con_write2;
  logic [AW2-1:0] con_addr2;
  logic [31:0]    con_in2;
  logic [31:0]    con_out2, con_out2_p;
  logic           dump_valid2, dump_last2, done2;
  logic [AW2-1:0] dump_addr2;
  logic [31:0]    dump_data2, cycle_count2, stall_count2;

  core_mem_dumper #(.HALT_COUNT(10), .DEPTH(DEPTH), .AW(AW), .RD_LAT(1)) u_dut (
    .CLK(CLK), .nrst(nrst), .if_inst(if_inst), .if_stall(if_stall),
    .con_write(con_write), .con_addr(con_addr), .con_in(con_in), .con_out(con_out),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_last(dump_last), .done(done),
    .cycle_count(cycle_count), .stall_count(stall_count)
  );

  core_mem_dumper #(.HALT_COUNT(10), .DEPTH(DEPTH2), .AW(AW2), .RD_LAT(2)) u_dut2 (
    .CLK(CLK), .nrst(nrst), .if_inst(if_inst), .if_stall(if_stall),
    .con_write(con_write2), .con_addr(con_addr2), .con_in(con_in2), .con_out(con_out2),
    .dump_valid(dump_valid2), .dump_ready(1'b1), .dump_addr(dump_addr2),
    .dump_data(dump_data2), .dump_last(dump_last2), .done(done2),
    .cycle_count(cycle_count2), .stall_count(stall_count2)
  );

  function automatic logic [31:0] mem_word(input int a);
    return 32'(a) * 32'd4 + 32'hA5;
  endfunction

  // Block-RAM models: one and two cycles of read latency.
  always @(posedge CLK) con_out <= mem_word(int'(con_addr));
  always @(posedge CLK) begin
    con_out2_p <= mem_word(int'(con_addr2));
    con_out2   <= con_out2_p;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          last;
  } word_t;
  word_t exp_q[$];

  typedef struct {
    int          nvar;
    int          nstall;
    logic [31:0] hinst;
    int          exp_cyc;
    int          exp_stall;
  } rec_t;
  rec_t tbl[4];

  int total = 0;
  int bad   = 0;
  int xfer_cnt = 0;
  int idx2 = 0;
  bit prev_hold = 0, prev_xfer = 0, rand_ready = 0;
  logic [AW-1:0] h_addr;
  logic [31:0]   h_data;
  logic          h_last;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Sampled on the falling edge: handshake rules and scoreboard for both instances.
  task automatic monitor();
    word_t w;
    if (!nrst) begin
      prev_hold = 0;
      prev_xfer = 0;
      idx2      = 0;
    end else begin
      if (prev_xfer) check("gap_after_xfer", 64'(dump_valid), 64'd0);
      if (prev_hold)
        check("hold_stable", 64'({dump_valid, dump_last, dump_addr, dump_data}),
              64'({1'b1, h_last, h_addr, h_data}));
      prev_xfer = dump_valid && dump_ready;
      prev_hold = dump_valid && !dump_ready;
      h_addr = dump_addr;
      h_data = dump_data;
      h_last = dump_last;
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(dump_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check("word", 64'({dump_addr, dump_data, dump_last}), 64'({w.addr, w.data, w.last}));
        end
        xfer_cnt++;
      end
      if (dump_valid2) begin
        if (idx2 >= DEPTH2) begin
          check("w2_extra", 64'(dump_addr2), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("w2_word", 64'({dump_addr2, dump_data2, dump_last2}),
                64'({AW2'(idx2), mem_word(idx2), idx2 == DEPTH2 - 1}));
        end
        idx2++;
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
    if (rand_ready) dump_ready = ($urandom_range(0, 99) < 30);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back('{AW'(i), mem_word(i), (i == DEPTH - 1)});
  endtask

  task automatic wait_done(input string nm, input int budget);
    for (int k = 0; k < budget && !done; k++) tick();
    check(nm, 64'(done), 64'd1);
  endtask

  task automatic reset_pulse();
    nrst = 1'b0;
    tick();
    exp_q.delete();
    nrst = 1'b1;
  endtask

  int edge_n, first, first2, base;
  bit seen;
  word_t w0;

  initial begin
    nrst = 1'b0; if_inst = '0; if_stall = 1'b0; dump_ready = 1'b0;

    // {varied instrs, stalled cycles, halt instr, cycle_count, stall_count}
    tbl[0] = '{0,  0, 32'h0000_0000, 10, 0};
    tbl[1] = '{0,  0, 32'h0000_0013, 11, 0};
    tbl[2] = '{40, 3, 32'h0000_0013, 51, 3};
    tbl[3] = '{7,  7, 32'h1234_5678, 18, 7};

    for (int r = 0; r < 4; r++) begin
      dump_ready = 1'b0; if_inst = '0; if_stall = 1'b0;
      nrst = 1'b0;
      tick();
      check("rst_ctl", 64'({con_addr, dump_valid, dump_addr, dump_last, done, con_write}), 64'd0);
      check("rst_data", 64'({dump_data, con_in}), 64'd0);
      check("rst_cnt", 64'({cycle_count, stall_count}), 64'd0);
      exp_q.delete();
      nrst = 1'b1;
      edge_n = 0; first = -1; first2 = -1;
      for (int k = 0; k < tbl[r].nvar; k++) begin
        if_inst  = 32'h100 + 32'(k);
        if_stall = (k < tbl[r].nstall);
        tick();
        edge_n++;
      end
      if_inst = tbl[r].hinst; if_stall = 1'b0;
      exp_q.push_back('{AW'(0), mem_word(0), 1'b0});
      for (int k = 0; k < 60 && (first < 0 || first2 < 0); k++) begin
        tick();
        edge_n++;
        if (edge_n == tbl[r].exp_cyc) if_stall = 1'b1;
        if (dump_valid && first < 0) first = edge_n;
        if (dump_valid2 && first2 < 0) first2 = edge_n;
      end
      check("halt_latency", 64'(first), 64'(tbl[r].exp_cyc + 3));
      check("halt_latency_rdlat2", 64'(first2), 64'(tbl[r].exp_cyc + 4));
      check("cycle_count", 64'(cycle_count), 64'(tbl[r].exp_cyc));
      check("stall_count", 64'(stall_count), 64'(tbl[r].exp_stall));
      w0 = exp_q.pop_front();
      check("word0", 64'({dump_valid, dump_addr, dump_data, dump_last}),
            64'({1'b1, w0.addr, w0.data, w0.last}));
    end

    // Alternating instructions never halt; then a steady one does.
    dump_ready = 1'b0; if_stall = 1'b0; if_inst = '0;
    reset_pulse();
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      if_inst = (k % 2 == 1) ? INST_B : INST_A;
      tick();
      if (dump_valid) seen = 1;
    end
    check("alt_no_halt", 64'(seen), 64'd0);
    check("alt_cycles", 64'(cycle_count), 64'd1000);
    if_inst = INST_A;
    first = -1;
    for (int j = 1; j <= 40 && first < 0; j++) begin
      tick();
      if (dump_valid) first = j;
    end
    check("alt_halt_latency", 64'(first), 64'd14);
    check("alt_cycles_frozen", 64'(cycle_count), 64'd1011);
    check("alt_word0", 64'({dump_addr, dump_data, dump_last}), 64'({AW'(0), mem_word(0), 1'b0}));

    // Full sweep, sink always ready.
    if_inst = '0; if_stall = 1'b0; dump_ready = 1'b1;
    reset_pulse();
    push_sweep();
    base = xfer_cnt;
    wait_done("sweep_done", 4000);
    check("sweep_count", 64'(xfer_cnt - base), 64'(DEPTH));
    check("sweep_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (5) tick();
    check("done_static", 64'({done, dump_valid, con_addr}), 64'({1'b1, 1'b0, AW'(DEPTH - 1)}));
    check("rdlat2_words", 64'(idx2), 64'(DEPTH2));
    check("rdlat2_done", 64'(done2), 64'd1);

    // Full sweep under random backpressure.
    dump_ready = 1'b0;
    reset_pulse();
    rand_ready = 1;
    push_sweep();
    base = xfer_cnt;
    wait_done("rand_done", 14000);
    rand_ready = 0;
    check("rand_count", 64'(xfer_cnt - base), 64'(DEPTH));
    check("rand_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a sweep, then a clean rerun from address 0.
    dump_ready = 1'b1;
    reset_pulse();
    push_sweep();
    base = xfer_cnt;
    for (int k = 0; k < 3000 && (xfer_cnt - base) < 500; k++) tick();
    check("reach_500", 64'(xfer_cnt - base), 64'd500);
    nrst = 1'b0;
    tick();
    check("mid_rst_ctl", 64'({con_addr, dump_valid, dump_addr, dump_last, done}), 64'd0);
    check("mid_rst_data", 64'(dump_data), 64'd0);
    check("mid_rst_cnt", 64'({cycle_count, stall_count}), 64'd0);
    exp_q.delete();
    nrst = 1'b1;
    tick();
    check("run_after_rst", 64'(cycle_count), 64'd1);
    push_sweep();
    base = xfer_cnt;
    wait_done("rerun_done", 4000);
    check("rerun_count", 64'(xfer_cnt - base), 64'(DEPTH));
    check("rerun_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
